// File: rtl/pma_region_table.sv
`default_nettype none
// ============================================================================
//  Module   : pma_region_table
//  Purpose  : Runtime-programmable physical-memory-attribute table. NrRules
//             entries of {base, length, attr} answer pipelined address lookups
//             with {executable, idempotent, cached}. The lowest-index match
//             wins. With no match the lookup returns DefaultAttr.
//  Ports    : clk_i, rst_i (async, active-high)
//             cfg_we_i / cfg_idx_i / cfg_field_i / cfg_wdata_i -> config write
//             cfg_ack_o / cfg_err_o  -> one-cycle write completion + reject flag
//             req_valid_i / req_ready_o / req_addr_i -> lookup request
//             resp_valid_o / resp_ready_i / resp_attr_o / resp_hit_o /
//             resp_idx_o -> registered lookup result
//  Revision : 1.0 - initial release
// ============================================================================
module pma_region_table #(
  parameter int                         NrRules     = 4,
  parameter int                         AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0] InitBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] InitLength = '0,
  parameter logic [NrRules*4-1:0]       InitAttr    = '0,
  parameter logic [3:0]                 DefaultAttr = 4'b0010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // configuration write port
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_ack_o,
  output logic                 cfg_err_o,
  // lookup request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  // lookup response
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [2:0]           resp_attr_o,
  output logic                 resp_hit_o,
  output logic [3:0]           resp_idx_o
);

  localparam logic [1:0] c_field_base = 2'd0;
  localparam logic [1:0] c_field_len  = 2'd1;
  localparam logic [1:0] c_field_attr = 2'd2;
  localparam int         c_lock_bit   = 3;

  // --------------------------------------------------------------------------
  // Region table
  // --------------------------------------------------------------------------
  logic [AddrWidth-1:0] r_base [NrRules];
  logic [AddrWidth-1:0] r_len  [NrRules];
  logic [3:0]           r_attr [NrRules];

  // --------------------------------------------------------------------------
  // Configuration write decode
  // --------------------------------------------------------------------------
  logic               w_idx_ok;
  logic               w_field_ok;
  logic               w_target_locked;
  logic               w_cfg_err;
  logic [NrRules-1:0] w_wr_sel;
  logic [NrRules-1:0] w_match;

  assign w_idx_ok   = ({1'b0, cfg_idx_i} < 5'(NrRules));
  assign w_field_ok = (cfg_field_i != 2'd3);

  // Lock bit of the addressed entry. The address is scanned rather than
  // indexed so an out-of-range index never reads past the table.
  always_comb begin
    w_target_locked = 1'b0;
    for (int i = 0; i < NrRules; i++) begin
      if ((cfg_idx_i == 4'(i)) && r_attr[i][c_lock_bit]) begin
        w_target_locked = 1'b1;
      end
    end
  end

  assign w_cfg_err = !w_idx_ok || !w_field_ok || w_target_locked;

  generate
    for (genvar gi = 0; gi < NrRules; gi++) begin : g_entry
      // End address carries one extra bit so a region touching the top of
      // the address space neither wraps nor loses its last bytes.
      logic [AddrWidth:0] w_end;

      assign w_end = {1'b0, r_base[gi]} + {1'b0, r_len[gi]};

      assign w_wr_sel[gi] = cfg_we_i && !w_cfg_err && (cfg_idx_i == 4'(gi));

      assign w_match[gi] = (r_len[gi] != '0)
                        && (req_addr_i >= r_base[gi])
                        && ({1'b0, req_addr_i} < w_end);
    end
  endgenerate

  // Rejected writes never reach w_wr_sel, so a locked entry stays frozen
  // until reset without needing a separate guard here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        r_base[i] <= InitBase[i*AddrWidth +: AddrWidth];
        r_len[i]  <= InitLength[i*AddrWidth +: AddrWidth];
        r_attr[i] <= InitAttr[i*4 +: 4];
      end
    end else begin
      for (int i = 0; i < NrRules; i++) begin
        if (w_wr_sel[i]) begin
          case (cfg_field_i)
            c_field_base: r_base[i] <= cfg_wdata_i;
            c_field_len:  r_len[i]  <= cfg_wdata_i;
            c_field_attr: r_attr[i] <= cfg_wdata_i[3:0];
            default:      r_attr[i] <= r_attr[i];
          endcase
        end
      end
    end
  end

  logic r_cfg_ack;
  logic r_cfg_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cfg_ack <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_ack <= cfg_we_i;
      r_cfg_err <= cfg_we_i && w_cfg_err;
    end
  end

  assign cfg_ack_o = r_cfg_ack;
  assign cfg_err_o = r_cfg_err;

  // --------------------------------------------------------------------------
  // Lookup: priority select, then one output register stage
  // --------------------------------------------------------------------------
  logic       w_hit;
  logic [3:0] w_idx;
  logic [2:0] w_attr;

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = 4'd0;
    w_attr = DefaultAttr[2:0];
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_idx  = 4'(i);
        w_attr = r_attr[i][2:0];
      end
    end
  end

  logic       r_resp_valid;
  logic [2:0] r_resp_attr;
  logic       r_resp_hit;
  logic [3:0] r_resp_idx;
  logic       w_accept;

  assign req_ready_o = !r_resp_valid || resp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Payload only loads on accept, so a stalled response is never recomputed
  // even if the table changes underneath it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_attr  <= 3'd0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= 4'd0;
    end else begin
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_attr  <= w_attr;
        r_resp_hit   <= w_hit;
        r_resp_idx   <= w_idx;
      end else if (resp_ready_i) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_attr_o  = r_resp_attr;
  assign resp_hit_o   = r_resp_hit;
  assign resp_idx_o   = r_resp_idx;

endmodule
`default_nettype wire

// File: tb/tb_pma_region_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pma_region_table
//  Purpose  : Self-checking bench for pma_region_table. A reference table
//             model predicts each lookup into a scoreboard queue. A monitor
//             compares every presented response and every ack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pma_region_table;

  localparam int NR = 4;
  localparam int AW = 64;
  localparam logic [NR*AW-1:0] c_init_base = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [NR*AW-1:0] c_init_len  = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
  localparam logic [NR*4-1:0]  c_init_attr = 16'h0007;
  localparam logic [3:0]       c_def_attr  = 4'b0010;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [1:0]    cfg_field = '0;
  logic [AW-1:0] cfg_wdata = '0;
  logic          cfg_ack_o, cfg_err_o;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid_o;
  logic          resp_ready = 1'b1;
  logic [2:0]    resp_attr_o;
  logic          resp_hit_o;
  logic [3:0]    resp_idx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRules    (NR),
    .AddrWidth  (AW),
    .InitBase   (c_init_base),
    .InitLength (c_init_len),
    .InitAttr   (c_init_attr),
    .DefaultAttr(c_def_attr)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_field_i (cfg_field),
    .cfg_wdata_i (cfg_wdata),
    .cfg_ack_o   (cfg_ack_o),
    .cfg_err_o   (cfg_err_o),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready),
    .resp_attr_o (resp_attr_o),
    .resp_hit_o  (resp_hit_o),
    .resp_idx_o  (resp_idx_o)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0] attr;
    logic       hit;
    logic [3:0] idx;
  } resp_t;

  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [3:0]    m_attr [NR];
  resp_t         sb_q [$];
  logic          m_valid = 1'b0;
  logic          m_ack = 1'b0;
  logic          m_err = 1'b0;

  // Offset-from-base form: addr is inside when it is at or above base and
  // its distance from base is below length (clipping at the top is implicit).
  function automatic resp_t ref_lookup(input logic [AW-1:0] a);
    resp_t r;
    r.attr = c_def_attr[2:0];
    r.hit  = 1'b0;
    r.idx  = 4'd0;
    for (int i = 0; i < NR; i++) begin
      if (m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
        r.attr = m_attr[i][2:0];
        r.hit  = 1'b1;
        r.idx  = 4'(i);
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_base[i] = c_init_base[i*AW +: AW];
        m_len[i]  = c_init_len[i*AW +: AW];
        m_attr[i] = c_init_attr[i*4 +: 4];
      end
      sb_q.delete();
      m_valid = 1'b0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
    end else begin
      logic rej;
      if (req_valid && (!m_valid || resp_ready)) begin
        sb_q.push_back(ref_lookup(req_addr));
        m_valid = 1'b1;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      rej = 1'b0;
      if (int'(cfg_idx) >= NR)      rej = 1'b1;
      else if (cfg_field == 2'd3)   rej = 1'b1;
      else if (m_attr[cfg_idx][3])  rej = 1'b1;
      m_ack = cfg_we;
      m_err = cfg_we && rej;
      if (cfg_we && !rej) begin
        case (cfg_field)
          2'd0:    m_base[cfg_idx] = cfg_wdata;
          2'd1:    m_len[cfg_idx]  = cfg_wdata;
          default: m_attr[cfg_idx] = cfg_wdata[3:0];
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    checks++;
    if (req_ready_o !== (!m_valid || resp_ready)) begin
      errors++;
      $display("FAIL req_ready got=%b exp=%b", req_ready_o, !m_valid || resp_ready);
    end
    checks++;
    if (resp_valid_o !== m_valid) begin
      errors++;
      $display("FAIL resp_valid got=%b exp=%b", resp_valid_o, m_valid);
    end
    checks++;
    if ({cfg_ack_o, cfg_err_o} !== {m_ack, m_err}) begin
      errors++;
      $display("FAIL cfg_ack_err got=%b%b exp=%b%b", cfg_ack_o, cfg_err_o, m_ack, m_err);
    end
    if (resp_valid_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got attr=%b hit=%b idx=%0d exp=none",
                 resp_attr_o, resp_hit_o, resp_idx_o);
      end else begin
        if ({resp_attr_o, resp_hit_o, resp_idx_o} !== sb_q[0]) begin
          errors++;
          $display("FAIL resp_data got attr=%b hit=%b idx=%0d exp attr=%b hit=%b idx=%0d",
                   resp_attr_o, resp_hit_o, resp_idx_o,
                   sb_q[0].attr, sb_q[0].hit, sb_q[0].idx);
        end
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [1:0] f, input logic [63:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = f; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lookup(input logic [63:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic resp_is(input string name, input logic [2:0] a, input logic h, input logic [3:0] i);
    check({name, "_valid"}, 64'(resp_valid_o), 64'd1);
    check({name, "_attr"},  64'(resp_attr_o),  64'(a));
    check({name, "_hit"},   64'(resp_hit_o),   64'(h));
    check({name, "_idx"},   64'(resp_idx_o),   64'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_ack",        64'(cfg_ack_o),    64'd0);
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_resp_valid", 64'(resp_valid_o), 64'd0);
    check("reset_attr",       64'(resp_attr_o),  64'd0);
    check("reset_hit",        64'(resp_hit_o),   64'd0);
    check("reset_idx",        64'(resp_idx_o),   64'd0);
    check("reset_ack_err",    64'({cfg_ack_o, cfg_err_o}), 64'd0);
    check("reset_req_ready",  64'(req_ready_o),  64'd1);

    // Reset-time table
    lookup(64'h8000_1000);       resp_is("init_hit", 3'b111, 1'b1, 4'd0);
    lookup(64'hC000_0000);       resp_is("init_end", 3'b010, 1'b0, 4'd0);

    // Top-of-space region, clipped rather than wrapping
    cfg_write(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
    cfg_write(4'd3, 2'd1, 64'h2000);
    cfg_write(4'd3, 2'd2, 64'h5);
    lookup(64'hFFFF_FFFF_FFFF_FFF8); resp_is("top_hit", 3'b101, 1'b1, 4'd3);
    lookup(64'h0);                   resp_is("top_nowrap", 3'b010, 1'b0, 4'd0);

    // Priority and overlap
    cfg_write(4'd0, 2'd0, 64'h1000);
    cfg_write(4'd0, 2'd1, 64'h1000);
    cfg_write(4'd0, 2'd2, 64'h1);
    cfg_write(4'd1, 2'd0, 64'h0);
    cfg_write(4'd1, 2'd1, 64'h10000);
    cfg_write(4'd1, 2'd2, 64'h4);
    lookup(64'h1800);            resp_is("prio_e0", 3'b001, 1'b1, 4'd0);
    lookup(64'h3000);            resp_is("prio_e1", 3'b100, 1'b1, 4'd1);

    // Lock
    cfg_write(4'd2, 2'd0, 64'h20000);
    cfg_write(4'd2, 2'd1, 64'h100);
    cfg_write(4'd2, 2'd2, 64'h9);
    check("lock_set_ack", 64'(cfg_ack_o), 64'd1);
    check("lock_set_err", 64'(cfg_err_o), 64'd0);
    cfg_write(4'd2, 2'd0, 64'h2000);
    check("lock_wr_ack", 64'(cfg_ack_o), 64'd1);
    check("lock_wr_err", 64'(cfg_err_o), 64'd1);
    lookup(64'h20010);           resp_is("lock_base_kept", 3'b001, 1'b1, 4'd2);

    // Illegal writes
    cfg_write(4'd4, 2'd0, 64'h1234);
    check("bad_idx_err", 64'({cfg_ack_o, cfg_err_o}), 64'b11);
    cfg_write(4'd0, 2'd3, 64'h0);
    check("bad_field_err", 64'({cfg_ack_o, cfg_err_o}), 64'b11);
    lookup(64'h1800);            resp_is("bad_unchanged", 3'b001, 1'b1, 4'd0);

    // Back-pressure while the matching entry is rewritten
    tick();
    resp_ready = 1'b0;
    lookup(64'h1800);
    cfg_write(4'd0, 2'd2, 64'h6);
    for (int k = 0; k < 3; k++) begin
      check("bp_req_ready", 64'(req_ready_o), 64'd0);
      resp_is("bp_hold", 3'b001, 1'b1, 4'd0);
      if (k < 2) tick();
    end
    resp_ready = 1'b1;
    tick();
    lookup(64'h1800);            resp_is("bp_new", 3'b110, 1'b1, 4'd0);

    // Same-cycle write and lookup: lookup sees the old table
    req_valid = 1'b1; req_addr = 64'h1800;
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 2'd2; cfg_wdata = 64'h3;
    tick();
    req_valid = 1'b0; cfg_we = 1'b0;
    resp_is("same_old", 3'b110, 1'b1, 4'd0);
    lookup(64'h1800);            resp_is("same_new", 3'b011, 1'b1, 4'd0);

    // Mid-operation reset releases the lock
    resp_ready = 1'b0;
    lookup(64'h1800);
    do_reset();
    resp_ready = 1'b1;
    cfg_write(4'd2, 2'd0, 64'h2000);
    check("unlock_err", 64'({cfg_ack_o, cfg_err_o}), 64'b10);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = ($urandom_range(0, 9) < 7) ? 64'($urandom_range(0, 'h11000)) : rnd64();
      if ($urandom_range(0, 9) == 0) req_addr = {32'hFFFF_FFFF, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_idx    = 4'($urandom_range(0, 5));
      cfg_field  = 2'($urandom_range(0, 3));
      case (cfg_field)
        2'd0: cfg_wdata = ($urandom_range(0, 4) != 0) ? 64'($urandom_range(0, 'h10000))
                                                      : {32'hFFFF_FFFF, $urandom};
        2'd1: cfg_wdata = ($urandom_range(0, 9) != 0) ? 64'($urandom_range(0, 'h8000)) : rnd64();
        default: cfg_wdata = {60'($urandom), ($urandom_range(0, 15) == 0), 3'($urandom)};
      endcase
      if (n == 750) begin
        cfg_we = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end
    req_valid = 1'b0; cfg_we = 1'b0; resp_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical-memory-attribute table. It generalises the static cached, non-idempotent and execute region rules of the core configuration into NrRules programmable entries. Each entry holds a base, a length and an attribute set, with per-entry lock. The block sits beside the MMU/PMP path. It answers pipelined address lookups (fetch or LSU) with cached, idempotent and executable attributes. The table is initialised at reset from parameters and can be reprogrammed through a simple configuration write port.

## Interface
- NrRules, 4: number of region entries (1..16).
- AddrWidth, 64: physical address width.
- InitBase, '0: NrRules×AddrWidth packed reset bases; entry i at bits [i*AddrWidth +: AddrWidth].
- InitLength, '0: NrRules×AddrWidth packed reset lengths.
- InitAttr, '0: NrRules×4 packed reset attributes.
- DefaultAttr, 4'b0010: attributes returned when no entry matches (idempotent only).
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- cfg_we_i  in  1  configuration write strobe.
- cfg_idx_i  in  4  target entry index.
- cfg_field_i  in  2  field select: 0 base, 1 length, 2 attr, 3 reserved.
- cfg_wdata_i  in  AddrWidth  write data; attr uses bits [3:0].
- cfg_ack_o  out  1  one-cycle pulse, one cycle after each cfg_we_i.
- cfg_err_o  out  1  valid with cfg_ack_o; write was rejected.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  lookup request accepted when high with req_valid_i.
- req_addr_i  in  AddrWidth  lookup address.
- resp_valid_o  out  1  lookup result valid.
- resp_ready_i  in  1  consumer accepts result.
- resp_attr_o  out  3  {executable, idempotent, cached}.
- resp_hit_o  out  1  some enabled entry matched.
- resp_idx_o  out  4  matching entry index (0 when no hit).

## Operation
- Attribute bits: [0] cached, [1] idempotent, [2] executable, [3] lock.
- Entry enabled iff length != 0.
- Match rule: base <= addr < base+length. The sum is computed in AddrWidth+1 bits, so a region reaching the top of the address space does not wrap. A region whose end exceeds 2^AddrWidth is clipped at the top.
- Priority: the lowest-index matching entry wins. With no match, the lookup returns DefaultAttr[2:0] and hit=0.
- Config write is rejected (cfg_err_o=1, table unchanged) when any of these holds:
  - cfg_idx_i >= NrRules;
  - cfg_field_i == 3;
  - the target entry's lock bit is set.
- Lock is sticky. Once set by an attr write, the entry stays read-only until rst_i. A write that sets lock also applies its other attribute bits in the same write.
- Lookup pipeline: one output register stage.
  - req_ready_o = !resp_valid_o || resp_ready_i.
  - On req_valid_i && req_ready_o, the result is computed from the current table and registered.
  - The response holds stable while resp_valid_o && !resp_ready_i.

## Timing
- Reset values:
  - table = Init* parameters;
  - resp_valid_o = 0, resp_attr_o = 0, resp_hit_o = 0, resp_idx_o = 0;
  - cfg_ack_o = 0, cfg_err_o = 0;
  - req_ready_o = 1 (combinational from resp_valid_o).
- Lookup latency: 1 cycle from accept to resp_valid_o. Full throughput of 1 per cycle while resp_ready_i=1.
- Config writes take effect at the clock edge of cfg_we_i. cfg_ack_o/cfg_err_o follow one cycle later.
- Simultaneous config write and lookup accept in the same cycle: the lookup uses the pre-write table. A lookup accepted in the next cycle sees the new value.
- Back-pressure: a held response is not recomputed if the table changes while it is stalled.
- rst_i asserted mid-operation clears any pending response and ack immediately (asynchronous). The table returns to the Init values and all locks clear.

## Test plan
- Reset defaults:
  - stimulus: InitBase e0=0x8000_0000, InitLength e0=0x4000_0000, InitAttr e0=4'b0111; lookup 0x8000_1000;
  - required: next cycle resp_valid_o=1, hit=1, idx=0, attr=3'b111. Lookup 0xC000_0000 (end exclusive) gives hit=0, attr=3'b010.
- Priority and overlap:
  - stimulus: e0=[0x1000,+0x1000) attr 3'b001; e1=[0x0,+0x10000) attr 3'b100; lookup 0x1800 then 0x3000;
  - required: idx=0 with attr=001, then idx=1 with attr=100.
- Lock:
  - stimulus: write e2 attr=4'b1001, then write e2 base=0x2000;
  - required: first write ack with err=0; second write ack with err=1 and base unchanged. After rst_i, writing e2 base gives err=0.
- Illegal writes:
  - stimulus: cfg_idx_i=NrRules, and separately cfg_field_i=3;
  - required: each returns cfg_ack_o=1, cfg_err_o=1, and the table is unchanged.
- Top-of-space region:
  - stimulus: base=0xFFFF_FFFF_FFFF_F000, length=0x2000; lookup 0xFFFF_FFFF_FFFF_FFF8 and 0x0;
  - required: first lookup hit=1; lookup 0x0 gives hit=0.
- Back-pressure and same-cycle write:
  - stimulus: hold resp_ready_i=0 for 3 cycles while writing the matching entry's attr;
  - required: req_ready_o=0 and the response stays stable with the old attr. After release, the next lookup reflects the new attr.
